// File: rtl/oflow_rx_pkg.sv
// Shared definitions for the overflow event receiver: notification bit positions,
// CPU register offsets, accept-FSM states and event-entry field widths.
package oflow_rx_pkg;

    localparam int unsigned MARKER_BIT    = 9;
    localparam int unsigned TYPE_BIT      = 8;
    localparam int unsigned WORD_W        = MARKER_BIT + 1;

    localparam int unsigned TYPE_WIDTH    = 1;
    localparam int unsigned TS_WIDTH      = 16;
    localparam int unsigned TS_LSB        = 16;
    localparam int unsigned EVT_VALID_BIT = 15;

    localparam logic [1:0] REG_STATUS  = 2'd0;
    localparam logic [1:0] REG_EVENT   = 2'd1;
    localparam logic [1:0] REG_PENDING = 2'd2;
    localparam logic [1:0] REG_CONTROL = 2'd3;

    localparam int unsigned STAT_EMPTY_BIT     = 0;
    localparam int unsigned STAT_FULL_BIT      = 1;
    localparam int unsigned STAT_MALFORMED_BIT = 2;
    localparam int unsigned STAT_COUNT_LSB     = 8;

    localparam int unsigned CTL_IRQ_EN_BIT  = 0;
    localparam int unsigned CTL_CLR_MAL_BIT = 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_ACK     = 2'd2
    } rx_state_e;

    // Stored entry is {type, core, task}.
    function automatic int unsigned entry_width(input int unsigned key_width);
        return TYPE_WIDTH + 2 * key_width;
    endfunction

endpackage

// File: rtl/oflow_rx_fifo.sv
// Single-clock event queue: push/pop in the same cycle both complete, count 0..DEPTH.
module oflow_rx_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == FULL_COUNT);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers are log2(DEPTH) wide, so wrap modulo DEPTH falls out of the adder.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/oflow_event_receiver.sv
// Receives overflow/underflow notifications, queues them for the CPU and tracks
// per-task pending overflows. Define OFLOW_RX_TIMESTAMP_EN to stamp events.
module oflow_event_receiver
    import oflow_rx_pkg::*;
#(
    parameter int unsigned KEY_WIDTH = 4,
    parameter int unsigned DEPTH     = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        evt_write,
    input  logic [31:0]                 evt_writedata,
    output logic                        evt_waitrequest,
    input  logic [1:0]                  cpu_address,
    input  logic                        cpu_read,
    output logic [31:0]                 cpu_readdata,
    input  logic                        cpu_write,
    input  logic [31:0]                 cpu_writedata,
    output logic                        irq,
    output logic [(1<<KEY_WIDTH)-1:0]   oflow_pending
);

    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned ENTRY_W = entry_width(KEY_WIDTH);
`ifdef OFLOW_RX_TIMESTAMP_EN
    localparam int unsigned FIFO_W  = ENTRY_W + TS_WIDTH;
`else
    localparam int unsigned FIFO_W  = ENTRY_W;
`endif

    rx_state_e                  r_state;
    rx_state_e                  w_next;
    logic [WORD_W-1:0]          r_word;
    logic                       w_capture;
    logic                       w_push;
    logic                       w_bad;
    logic                       w_pop;
    logic                       w_full;
    logic                       w_empty;
    logic [CNT_W-1:0]           w_count;
    logic [ENTRY_W-1:0]         w_entry;
    logic [FIFO_W-1:0]          w_fifo_din;
    logic [FIFO_W-1:0]          w_head;
    logic [(1<<KEY_WIDTH)-1:0]  r_pending;
    logic                       r_malformed;
    logic                       r_irq_en;
    logic                       r_irq;
    logic [31:0]                w_rdata;
    logic [31:0]                r_readdata;
    logic                       w_ctl_wr;
    logic                       w_unused;

    assign w_unused = ^{evt_writedata[31:WORD_W], cpu_writedata[31:2]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Full is only checked in IDLE; pops can only make room, so CAPTURE can always push.
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_push    = 1'b0;
        w_bad     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (evt_write && !w_full) begin
                    w_next    = S_CAPTURE;
                    w_capture = 1'b1;
                end
            end
            S_CAPTURE: begin
                w_next = S_ACK;
                w_push = r_word[MARKER_BIT];
                w_bad  = ~r_word[MARKER_BIT];
            end
            S_ACK:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign evt_waitrequest = (r_state != S_ACK);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word <= '0;
        end else if (w_capture) begin
            r_word <= evt_writedata[WORD_W-1:0];
        end
    end

    assign w_entry = {r_word[TYPE_BIT], r_word[2*KEY_WIDTH-1:0]};

`ifdef OFLOW_RX_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] r_ts;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
        end
    end

    assign w_fifo_din = {r_ts, w_entry};
`else
    assign w_fifo_din = w_entry;
`endif

    assign w_pop = cpu_read && (cpu_address == REG_EVENT) && !w_empty;

    oflow_rx_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_fifo_din),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_ctl_wr = cpu_write && (cpu_address == REG_CONTROL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending   <= '0;
            r_malformed <= 1'b0;
            r_irq_en    <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            if (w_push) begin
                r_pending[r_word[KEY_WIDTH-1:0]] <= r_word[TYPE_BIT];
            end
            if (w_bad) begin
                r_malformed <= 1'b1;
            end else if (w_ctl_wr && cpu_writedata[CTL_CLR_MAL_BIT]) begin
                r_malformed <= 1'b0;
            end
            if (w_ctl_wr) begin
                r_irq_en <= cpu_writedata[CTL_IRQ_EN_BIT];
            end
            r_irq <= r_irq_en & ~w_empty;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (cpu_address)
            REG_STATUS: begin
                w_rdata[STAT_EMPTY_BIT]               = w_empty;
                w_rdata[STAT_FULL_BIT]                = w_full;
                w_rdata[STAT_MALFORMED_BIT]           = r_malformed;
                w_rdata[STAT_COUNT_LSB +: CNT_W]      = w_count;
            end
            REG_EVENT: begin
                if (!w_empty) begin
                    w_rdata[EVT_VALID_BIT]  = 1'b1;
                    w_rdata[ENTRY_W-1:0]    = w_head[ENTRY_W-1:0];
`ifdef OFLOW_RX_TIMESTAMP_EN
                    w_rdata[TS_LSB +: TS_WIDTH] = w_head[FIFO_W-1:ENTRY_W];
`endif
                end
            end
            REG_PENDING: w_rdata[(1<<KEY_WIDTH)-1:0] = r_pending;
            REG_CONTROL: w_rdata[CTL_IRQ_EN_BIT]     = r_irq_en;
            default:     w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= cpu_read ? w_rdata : '0;
        end
    end

    assign cpu_readdata  = r_readdata;
    assign irq           = r_irq;
    assign oflow_pending = r_pending;

endmodule

// File: tb/tb_oflow_event_receiver.sv
// Self-checking bench for oflow_event_receiver: vector table, corner sequences, random vs model.
module tb_oflow_event_receiver;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        evt_write = 1'b0;
    logic [31:0] evt_writedata = '0;
    logic        evt_waitrequest;
    logic [1:0]  cpu_address = '0;
    logic        cpu_read = 1'b0;
    logic [31:0] cpu_readdata;
    logic        cpu_write = 1'b0;
    logic [31:0] cpu_writedata = '0;
    logic        irq;
    logic [15:0] oflow_pending;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef OFLOW_RX_TIMESTAMP_EN
    localparam logic [31:0] EVT_MASK = 32'h0000_FFFF;
`else
    localparam logic [31:0] EVT_MASK = 32'hFFFF_FFFF;
`endif

    // Reference model state
    logic [31:0] mq[$];
    logic [15:0] m_pend;
    bit          m_mal;
    bit          m_irq_en;

    oflow_event_receiver #(.KEY_WIDTH(4), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .evt_write       (evt_write),
        .evt_writedata   (evt_writedata),
        .evt_waitrequest (evt_waitrequest),
        .cpu_address     (cpu_address),
        .cpu_read        (cpu_read),
        .cpu_readdata    (cpu_readdata),
        .cpu_write       (cpu_write),
        .cpu_writedata   (cpu_writedata),
        .irq             (irq),
        .oflow_pending   (oflow_pending)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pend   = '0;
        m_mal    = 0;
        m_irq_en = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        evt_write = 1'b0;
        cpu_read = 1'b0;
        cpu_write = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Index i counts the cycle whose rising edge would complete the transfer.
    task automatic evt_wr(input logic [31:0] d, input int budget, output int cyc);
        int i;
        @(negedge clk);
        evt_write = 1'b1;
        evt_writedata = d;
        i = 1;
        while (evt_waitrequest && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (evt_waitrequest) begin
            evt_write = 1'b0;
            cyc = budget + 1000;
        end else begin
            @(posedge clk);
            #1;
            evt_write = 1'b0;
            cyc = i;
        end
    endtask

    task automatic cpu_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        cpu_address = a;
        cpu_read = 1'b1;
        @(negedge clk);
        cpu_read = 1'b0;
        d = cpu_readdata;
    endtask

    task automatic cpu_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        cpu_address = a;
        cpu_writedata = d;
        cpu_write = 1'b1;
        @(negedge clk);
        cpu_write = 1'b0;
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = '0;
        s[0] = (mq.size() == 0);
        s[1] = (mq.size() == DEPTH);
        s[2] = m_mal;
        s[11:8] = 4'(mq.size());
        return s;
    endfunction

    // Notifier-side rules: marker gates queueing, type decides set/clear of pending[task].
    task automatic model_notify(input logic [31:0] w);
        if (w[9]) begin
            mq.push_back(32'h8000 | {23'd0, w[8:0]});
            m_pend[w[3:0]] = w[8];
        end else begin
            m_mal = 1;
        end
    endtask

    typedef struct {
        logic [31:0] word;
        logic [31:0] exp_stat;
        logic [31:0] exp_evt;
        logic [15:0] exp_pend;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [31:0] rd, rd2, w;
        int cyc;

        vecs[0] = '{32'h0000_03A3, 32'h0000_0100, 32'h0000_81A3, 16'h0008};
        vecs[1] = '{32'h0000_02A3, 32'h0000_0100, 32'h0000_80A3, 16'h0000};
        vecs[2] = '{32'h0000_035F, 32'h0000_0100, 32'h0000_815F, 16'h8000};
        vecs[3] = '{32'h0000_0300, 32'h0000_0100, 32'h0000_8100, 16'h8001};
        vecs[4] = '{32'h0000_01A3, 32'h0000_0005, 32'h0000_0000, 16'h8001};
        vecs[5] = '{32'h0000_020F, 32'h0000_0104, 32'h0000_800F, 16'h0001};
        vecs[6] = '{32'hABCD_F2E0, 32'h0000_0104, 32'h0000_80E0, 16'h0000};

        do_reset();
        check("rst_waitreq", {31'd0, evt_waitrequest}, 32'd1);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_pending", {16'd0, oflow_pending}, 32'd0);
        check("rst_readdata", cpu_readdata, 32'd0);
        cpu_rd(2'd0, rd);
        check("rst_status", rd, 32'h0000_0001);
        cpu_rd(2'd3, rd);
        check("rst_control", rd, 32'd0);

        for (int i = 0; i < 7; i++) begin
            evt_wr(vecs[i].word, 20, cyc);
            check($sformatf("vec%0d_cycles", i), 32'(cyc), 32'd3);
            check($sformatf("vec%0d_pend_port", i), {16'd0, oflow_pending}, {16'd0, vecs[i].exp_pend});
            cpu_rd(2'd2, rd);
            check($sformatf("vec%0d_pend_reg", i), rd, {16'd0, vecs[i].exp_pend});
            cpu_rd(2'd0, rd);
            check($sformatf("vec%0d_status", i), rd, vecs[i].exp_stat);
            cpu_rd(2'd1, rd);
            check($sformatf("vec%0d_event", i), rd & EVT_MASK, vecs[i].exp_evt);
        end
        cpu_wr(2'd3, 32'h2);
        cpu_rd(2'd0, rd);
        check("mal_clear_status", rd, 32'h0000_0001);
        cpu_rd(2'd3, rd);
        check("mal_clear_ctl_reads0", rd, 32'd0);

        // Two queued events pop in order, then the empty read returns 0.
        evt_wr(32'h3A3, 20, cyc);
        evt_wr(32'h2A3, 20, cyc);
        check("order_pend", {16'd0, oflow_pending}, 32'd0);
        cpu_rd(2'd1, rd);
        check("order_ev0", rd & EVT_MASK, 32'h81A3);
        cpu_rd(2'd1, rd);
        check("order_ev1", rd & EVT_MASK, 32'h80A3);
        cpu_rd(2'd1, rd);
        check("order_empty", rd, 32'd0);
        cpu_rd(2'd0, rd);
        check("order_status_after_empty_rd", rd, 32'h0000_0001);

`ifdef OFLOW_RX_TIMESTAMP_EN
        evt_wr(32'h311, 20, cyc);
        repeat (7) @(negedge clk);
        evt_wr(32'h322, 20, cyc);
        cpu_rd(2'd1, rd);
        cpu_rd(2'd1, rd2);
        check("ts_low0", rd & 32'hFFFF, 32'h8111);
        check("ts_low1", rd2 & 32'hFFFF, 32'h8122);
        check("ts_delta", {16'd0, rd2[31:16] - rd[31:16]}, 32'd10);
`endif

        // Fill, then a 9th write must stall until a pop makes room.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            w = 32'h200 | ($urandom & 32'hFF) | (($urandom & 1) << 8);
            evt_wr(w, 20, cyc);
            model_notify(w);
        end
        cpu_rd(2'd0, rd);
        check("full_status", rd, 32'h0000_0802);
        w = 32'h3C5;
        fork
            evt_wr(w, 60, cyc);
            begin
                repeat (10) @(negedge clk);
                check("full_stall_waitreq", {31'd0, evt_waitrequest}, 32'd1);
                cpu_rd(2'd1, rd);
                check("full_pop_head", rd & EVT_MASK, mq.pop_front());
            end
        join
        model_notify(w);
        n_tests++;
        if (cyc <= 10 || cyc > 60) begin
            n_fail++;
            $display("FAIL full_stall_len: got %0d cycles required 11..60", cyc);
        end
        cpu_rd(2'd0, rd);
        check("full_after_retry", rd, 32'h0000_0802);
        for (int i = 0; i < DEPTH; i++) begin
            cpu_rd(2'd1, rd);
            check($sformatf("full_drain%0d", i), rd & EVT_MASK, mq.pop_front());
        end
        cpu_rd(2'd1, rd);
        check("full_drain_empty", rd, 32'd0);

        // Pop and push land on the same edge; count must stay at 1.
        evt_wr(32'h3A1, 20, cyc);
        fork
            evt_wr(32'h2B2, 20, cyc);
            begin
                @(negedge clk);
                cpu_rd(2'd1, rd);
            end
        join
        check("samecyc_pop", rd & EVT_MASK, 32'h81A1);
        cpu_rd(2'd0, rd);
        check("samecyc_status", rd, 32'h0000_0100);
        cpu_rd(2'd1, rd);
        check("samecyc_push", rd & EVT_MASK, 32'h80B2);

        // irq timing around push and pop.
        do_reset();
        cpu_wr(2'd3, 32'h1);
        @(negedge clk);
        evt_write = 1'b1;
        evt_writedata = 32'h3A3;
        @(negedge clk);
        @(negedge clk);
        check("irq_ack_phase", {31'd0, evt_waitrequest}, 32'd0);
        check("irq_not_yet", {31'd0, irq}, 32'd0);
        @(posedge clk);
        #1;
        evt_write = 1'b0;
        check("irq_rise", {31'd0, irq}, 32'd1);
        cpu_rd(2'd1, rd);
        check("irq_pop_data", rd & EVT_MASK, 32'h81A3);
        check("irq_still_high", {31'd0, irq}, 32'd1);
        @(negedge clk);
        check("irq_fall", {31'd0, irq}, 32'd0);

        // Reset while a word sits in CAPTURE: it must not appear afterwards.
        do_reset();
        @(negedge clk);
        evt_write = 1'b1;
        evt_writedata = 32'h3A3;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_waitreq", {31'd0, evt_waitrequest}, 32'd1);
        @(negedge clk);
        evt_write = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        cpu_rd(2'd0, rd);
        check("midrst_status", rd, 32'h0000_0001);
        check("midrst_pending", {16'd0, oflow_pending}, 32'd0);
        cpu_rd(2'd1, rd);
        check("midrst_event", rd, 32'd0);

        // Randomized traffic against the model.
        do_reset();
        for (int it = 0; it < 300; it++) begin
            int op;
            logic [1:0] a;
            op = $urandom_range(0, 2);
            if (op == 0 && mq.size() == DEPTH) op = 1;
            case (op)
                0: begin
                    w = $urandom;
                    w[9] = ($urandom_range(0, 7) != 0);
                    evt_wr(w, 20, cyc);
                    model_notify(w);
                    check("rnd_wr_cycles", 32'(cyc), 32'd3);
                end
                1: begin
                    a = 2'($urandom_range(0, 3));
                    cpu_rd(a, rd);
                    case (a)
                        2'd0: check("rnd_status", rd, model_status());
                        2'd1: check("rnd_event", rd & EVT_MASK, (mq.size() != 0) ? mq.pop_front() : 32'd0);
                        2'd2: check("rnd_pending", rd, {16'd0, m_pend});
                        default: check("rnd_control", rd, {31'd0, m_irq_en});
                    endcase
                end
                default: begin
                    a = 2'($urandom_range(0, 3));
                    w = $urandom;
                    cpu_wr(a, w);
                    if (a == 2'd3) begin
                        m_irq_en = w[0];
                        if (w[1]) m_mal = 0;
                    end
                end
            endcase
            @(negedge clk);
            check("rnd_irq", {31'd0, irq}, {31'd0, m_irq_en && (mq.size() != 0)});
            check("rnd_pend_port", {16'd0, oflow_pending}, {16'd0, m_pend});
        end
        cpu_rd(2'd0, rd);
        check("rnd_final_status", rd, model_status());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
